// File: rtl/wb_dual_port_ram_if.sv
// Wishbone instruction/data bus bundle for wb_dual_port_ram.
// The slave modport is the RAM side, the master modport is the initiator side.
interface wb_dual_port_ram_if;
    logic [31:0] iwb_adr_i;
    logic        iwb_cyc_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;

    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic        dwb_ack_o;
    logic        dwb_err_o;

    modport slave (
        input  iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        output iwb_dat_o, iwb_ack_o,
        input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
        output dwb_dat_o, dwb_ack_o, dwb_err_o
    );

    modport master (
        output iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        input  iwb_dat_o, iwb_ack_o,
        output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i, dwb_cyc_i, dwb_stb_i,
        input  dwb_dat_o, dwb_ack_o, dwb_err_o
    );
endinterface

// File: rtl/wb_dual_port_ram.sv
// Unified I/D Wishbone classic RAM with tohost compliance monitor.
// Define WB_RAM_WAIT_EN to insert WAIT_STATES wait cycles before each ack.

// Per-port cycle controller: IDLE -> (WAIT) -> ACK -> IDLE; `access` marks the serving edge.
module wb_dual_port_ram_fsm #(
    parameter int WAIT_STATES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic access
);
`ifdef WB_RAM_WAIT_EN
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic {S_IDLE, S_ACK} state_t;
    localparam int unused_wait_states = WAIT_STATES;
`endif

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
`ifdef WB_RAM_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef WB_RAM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
`ifdef WB_RAM_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
`ifdef WB_RAM_WAIT_EN
                    // Loaded with WAIT_STATES-1: the IDLE edge already counts as one wait cycle.
                    if (WAIT_STATES != 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(WAIT_STATES - 1);
                    end else begin
                        access  = 1'b1;
                        state_d = S_ACK;
                    end
`else
                    access  = 1'b1;
                    state_d = S_ACK;
`endif
                end
            end
`ifdef WB_RAM_WAIT_EN
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

module wb_dual_port_ram #(
    parameter int    ADDR_WIDTH  = 13,
    parameter int    TOHOST_WORD = 1024,
    parameter string INIT_FILE   = "",
    parameter int    WAIT_STATES = 2
) (
    input  logic                clk,
    input  logic                rst,
    wb_dual_port_ram_if.slave   bus,
    output logic [31:0]         tohost_data_o,
    output logic                test_done_o,
    output logic                test_pass_o
);
    localparam int                    DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [31:0]           NOP        = 32'h0000_0013;
    localparam logic [ADDR_WIDTH-1:0] TOHOST_IDX = ADDR_WIDTH'(TOHOST_WORD);

    logic [31:0] mem [DEPTH];

    // Unloaded words read back as NOP so a stray fetch does not trap.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = NOP;
    end

    logic [ADDR_WIDTH-1:0] i_idx, d_idx;
    logic                  i_req, d_req, i_access, d_access;
    logic                  d_err, d_wr;
    logic [31:0]           d_old, d_merged;
    logic [31:0]           i_dat_q, d_dat_q;
    logic                  i_ack_q, d_ack_q, d_err_q;
    logic                  unused_bits;

    assign i_idx = bus.iwb_adr_i[ADDR_WIDTH+1:2];
    assign d_idx = bus.dwb_adr_i[ADDR_WIDTH+1:2];
    assign i_req = bus.iwb_cyc_i & bus.iwb_stb_i;
    assign d_req = bus.dwb_cyc_i & bus.dwb_stb_i;
    // I-port aliases on upper address bits; only the D-port faults on them.
    assign d_err = |bus.dwb_adr_i[31:ADDR_WIDTH+2];
    assign unused_bits = ^{bus.iwb_adr_i[31:ADDR_WIDTH+2], bus.iwb_adr_i[1:0], bus.dwb_adr_i[1:0]};

    wb_dual_port_ram_fsm #(.WAIT_STATES(WAIT_STATES)) u_ifsm (
        .clk(clk), .rst(rst), .req(i_req), .access(i_access)
    );
    wb_dual_port_ram_fsm #(.WAIT_STATES(WAIT_STATES)) u_dfsm (
        .clk(clk), .rst(rst), .req(d_req), .access(d_access)
    );

    assign d_old = mem[d_idx];
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign d_merged[8*b +: 8] = bus.dwb_sel_i[b] ? bus.dwb_dat_i[8*b +: 8] : d_old[8*b +: 8];
    end
    assign d_wr = d_access & bus.dwb_we_i & ~d_err;

    // Gated by rst so a write landing on the same edge as reset is dropped.
    always_ff @(posedge clk) begin
        if (d_wr && !rst) mem[d_idx] <= d_merged;
    end

    // Non-blocking read of mem gives read-before-write against a same-edge D-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ack_q <= 1'b0;
            i_dat_q <= NOP;
        end else begin
            i_ack_q <= i_access;
            if (i_access) i_dat_q <= mem[i_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_ack_q <= 1'b0;
            d_err_q <= 1'b0;
            d_dat_q <= '0;
        end else begin
            d_ack_q <= d_access & ~d_err;
            d_err_q <= d_access & d_err;
            if (d_access) d_dat_q <= d_err ? '0 : (bus.dwb_we_i ? d_merged : d_old);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost_data_o <= '0;
            test_done_o   <= 1'b0;
            test_pass_o   <= 1'b0;
        end else if (d_wr && d_idx == TOHOST_IDX) begin
            tohost_data_o <= d_merged;
            if (!test_done_o && d_merged != '0) begin
                test_done_o <= 1'b1;
                test_pass_o <= (d_merged == 32'd1);
            end
        end
    end

    assign bus.iwb_ack_o = i_ack_q;
    assign bus.iwb_dat_o = i_dat_q;
    assign bus.dwb_ack_o = d_ack_q;
    assign bus.dwb_err_o = d_err_q;
    assign bus.dwb_dat_o = d_dat_q;
endmodule
